// File: rtl/ysyx_041514_if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_041514_if_stage_pkg
// Description : Shared constants for the instruction-fetch stage: control-bus
//               bit index, bubble instruction, PC reset address and the
//               2-bit fetch FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_041514_if_stage_pkg;

    // Bit of the 6-bit stall/flush control buses owned by the IF stage
    localparam int          c_ctrlbus_if    = 1;

    // addi x0,x0,0 - the canonical bubble
    localparam logic [31:0] c_nop_inst      = 32'h0000_0013;

    localparam logic [63:0] c_pc_reset_addr = 64'h0000_0000_8000_0000;

    // Fetch FSM state encodings
    localparam logic [1:0]  c_st_idle       = 2'd0;
    localparam logic [1:0]  c_st_wait       = 2'd1;
    localparam logic [1:0]  c_st_hold       = 2'd2;
    localparam logic [1:0]  c_st_drop       = 2'd3;

    // Instructions must be 4-byte aligned
    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_041514_if_inst_buf.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_041514_if_inst_buf
// Description : One-entry holding buffer for an icache response that arrived
//               while decode was stalled.
//   clk, rst        : clock, synchronous active-high reset
//   i_load          : capture i_inst / i_pc, mark entry valid
//   i_clear         : drop the entry (takes priority over i_load)
//   o_valid/o_inst/o_pc : stored entry
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_041514_if_inst_buf #(
    parameter int XLEN   = 64,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [INST_W-1:0] i_inst,
    input  logic [XLEN-1:0]   i_pc,
    output logic              o_valid,
    output logic [INST_W-1:0] o_inst,
    output logic [XLEN-1:0]   o_pc
);

    logic              r_valid;
    logic [INST_W-1:0] r_inst;
    logic [XLEN-1:0]   r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_inst  <= '0;
            r_pc    <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_inst  <= i_inst;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_inst  = r_inst;
    assign o_pc    = r_pc;

endmodule
`default_nettype wire

// File: rtl/ysyx_041514_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_041514_if_stage
// Description : Instruction-fetch stage. Issues one icache request at a time
//               from the PC register's pc/fetch-enable, absorbs the response,
//               parks it in a one-entry buffer while decode is stalled,
//               discards responses after a flush, and drives the IF/ID
//               pipeline register.
//   stall_valid_i / flush_valid_i : control buses (bit c_ctrlbus_if used)
//   pc_i, read_req_i              : current PC and fetch enable
//   if_req_*                      : icache request channel
//   if_rdata_valid_i, if_rdata_i  : icache response (single-cycle pulse)
//   fetch_busy_o                  : asks control unit to stall the PC
//   inst_*_o                      : IF/ID register outputs
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_041514_if_stage
    import ysyx_041514_if_stage_pkg::*;
#(
    parameter int                XLEN     = 64,
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = c_nop_inst
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall_valid_i,
    input  logic [5:0]        flush_valid_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              read_req_i,
    output logic              if_req_valid_o,
    output logic [ADDR_W-1:0] if_req_addr_o,
    input  logic              if_req_ready_i,
    input  logic              if_rdata_valid_i,
    input  logic [INST_W-1:0] if_rdata_i,
    output logic              fetch_busy_o,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [XLEN-1:0]   inst_pc_o,
    output logic              inst_misalign_o
);

    logic              w_stall;
    logic              w_flush;
    logic              w_mis;
    logic              w_idle;
    logic              w_hs;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [XLEN-1:0]   r_req_pc;

    logic              w_new_valid;
    logic [INST_W-1:0] w_new_inst;
    logic [XLEN-1:0]   w_new_pc;
    logic              w_new_mis;

    logic              w_buf_load;
    logic              w_buf_clear;
    logic              w_buf_valid;
    logic [INST_W-1:0] w_buf_inst;
    logic [XLEN-1:0]   w_buf_pc;

    logic              r_inst_valid;
    logic [INST_W-1:0] r_inst;
    logic [XLEN-1:0]   r_inst_pc;
    logic              r_inst_mis;

    // Other control-bus bits and upper PC bits belong to other consumers
    logic              w_unused_bits;
    assign w_unused_bits = ^{stall_valid_i, flush_valid_i, pc_i[XLEN-1:ADDR_W]};

    assign w_stall = stall_valid_i[c_ctrlbus_if];
    assign w_flush = flush_valid_i[c_ctrlbus_if];
    assign w_mis   = pc_misaligned(pc_i[1:0]);
    assign w_idle  = (r_state == c_st_idle);

    // ------------------------------------------------------------------
    // Request channel
    // ------------------------------------------------------------------
    assign if_req_valid_o = w_idle & read_req_i & ~w_mis & ~w_stall & ~w_flush & ~rst;
    assign if_req_addr_o  = pc_i[ADDR_W-1:0];
    assign w_hs           = if_req_valid_o & if_req_ready_i;

    // Busy is built without stall/flush so the control unit, which derives
    // stall/flush from busy, never sees a combinational loop through here.
    assign fetch_busy_o = ~rst & (
          (w_idle & read_req_i & ~w_mis & ~if_req_ready_i)
        | ((r_state == c_st_wait) & ~if_rdata_valid_i)
        | (r_state == c_st_hold)
        | (r_state == c_st_drop));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_pc <= '0;
        end else if (w_hs) begin
            r_req_pc <= pc_i;
        end
    end

    // ------------------------------------------------------------------
    // Fetch FSM: next state and the instruction offered to IF/ID
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_new_valid = 1'b0;
        w_new_inst  = NOP_INST;
        w_new_pc    = '0;
        w_new_mis   = 1'b0;
        w_buf_load  = 1'b0;
        w_buf_clear = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_hs) begin
                    w_state_nxt = c_st_wait;
                end else if (w_mis & read_req_i & ~w_stall & ~w_flush) begin
                    // Misaligned PC: no icache access, a trapping bubble instead
                    w_new_valid = 1'b1;
                    w_new_pc    = pc_i;
                    w_new_mis   = 1'b1;
                end
            end
            c_st_wait: begin
                if (if_rdata_valid_i) begin
                    w_state_nxt = c_st_idle;
                    if (w_flush) begin
                        w_state_nxt = c_st_idle;
                    end else if (w_stall) begin
                        w_buf_load  = 1'b1;
                        w_state_nxt = c_st_hold;
                    end else begin
                        w_new_valid = 1'b1;
                        w_new_inst  = if_rdata_i;
                        w_new_pc    = r_req_pc;
                    end
                end else if (w_flush) begin
                    // Response still in flight: swallow it when it lands
                    w_state_nxt = c_st_drop;
                end
            end
            c_st_hold: begin
                if (w_flush) begin
                    w_buf_clear = 1'b1;
                    w_state_nxt = c_st_idle;
                end else if (~w_stall & w_buf_valid) begin
                    w_new_valid = 1'b1;
                    w_new_inst  = w_buf_inst;
                    w_new_pc    = w_buf_pc;
                    w_buf_clear = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_drop: begin
                if (if_rdata_valid_i) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    ysyx_041514_if_inst_buf #(
        .XLEN   (XLEN),
        .INST_W (INST_W)
    ) u_inst_buf (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_buf_load),
        .i_clear (w_buf_clear),
        .i_inst  (if_rdata_i),
        .i_pc    (r_req_pc),
        .o_valid (w_buf_valid),
        .o_inst  (w_buf_inst),
        .o_pc    (w_buf_pc)
    );

    // ------------------------------------------------------------------
    // IF/ID pipeline register: flush > stall > new instruction > bubble
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_inst_valid <= 1'b0;
            r_inst       <= NOP_INST;
            r_inst_pc    <= '0;
            r_inst_mis   <= 1'b0;
        end else if (w_stall) begin
            r_inst_valid <= r_inst_valid;
        end else if (w_new_valid) begin
            r_inst_valid <= 1'b1;
            r_inst       <= w_new_inst;
            r_inst_pc    <= w_new_pc;
            r_inst_mis   <= w_new_mis;
        end else begin
            r_inst_valid <= 1'b0;
            r_inst       <= NOP_INST;
            r_inst_pc    <= '0;
            r_inst_mis   <= 1'b0;
        end
    end

    assign inst_valid_o    = r_inst_valid;
    assign inst_o          = r_inst;
    assign inst_pc_o       = r_inst_pc;
    assign inst_misalign_o = r_inst_mis;

endmodule
`default_nettype wire
